terminal_dumper: RTL

TERMINAL_DUMPER -- requirements
Module: terminal_dumper

---
 rtl/terminal_dumper.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/terminal_dumper.sv
// terminal_dumper: walks the terminal text RAM row by row and sends each
// character over a UART (8N1), closing every row with CR LF. Non-printable
// characters are sent as '.'. A dump is started by a one-cycle start pulse.
//
// Handshake: start is a single-cycle request, taken only in IDLE; busy is
// high from the accepting edge until the last stop bit ends, and done
// pulses for one cycle (with busy low) when the dump completes.
module terminal_dumper #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    CR     = 3'd4,
    LF     = 3'd5,
    FINISH = 3'd6
  } state_t;

  localparam int              BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [11:0]     COL_LAST  = 12'(COLS - 1);
  localparam logic [11:0]     ROW_LAST  = 12'(ROWS - 1);

  state_t         state_q, state_d;
  logic [11:0]    addr_q, addr_d;
  logic [11:0]    row_q, row_d;
  logic [11:0]    col_q, col_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [7:0]     byte_q, byte_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           frame_end;
  logic [3:0]     data_sel;

  // Next-state, counters and the registered serial line value.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    row_d     = row_q;
    col_d     = col_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    data_sel  = 4'd0;
    frame_end = (baud_q == BAUD_LAST) && (bit_q == 4'd9);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = 12'd0;
          row_d   = 12'd0;
          col_d   = 12'd0;
          busy_d  = 1'b1;
        end
      end
      // The RAM needs one more cycle before its data is valid.
      FETCH: state_d = WAIT;
      WAIT: begin
        byte_d  = (text_data >= 8'h20 && text_data < 8'h7F) ? text_data : 8'h2E;
        baud_d  = '0;
        bit_d   = 4'd0;
        state_d = SEND;
      end
      SEND, CR, LF: begin
        if (frame_end) begin
          baud_d = '0;
          bit_d  = 4'd0;
          if (state_q == SEND) begin
            if (col_q < COL_LAST) begin
              col_d   = col_q + 12'd1;
              addr_d  = addr_q + 12'd1;
              state_d = FETCH;
            end else begin
              byte_d  = 8'h0D;
              state_d = CR;
            end
          end else if (state_q == CR) begin
            byte_d  = 8'h0A;
            state_d = LF;
          end else if (row_q < ROW_LAST) begin
            row_d   = row_q + 12'd1;
            col_d   = 12'd0;
            addr_d  = addr_q + 12'd1;
            state_d = FETCH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end else if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          bit_d  = bit_q + 4'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx follows the bit that will be on the line after this edge.
    if (state_d == SEND || state_d == CR || state_d == LF) begin
      data_sel = bit_d - 4'd1;
      if (bit_d == 4'd0)      tx_d = 1'b0;
      else if (bit_d == 4'd9) tx_d = 1'b1;
      else                    tx_d = byte_d[data_sel[2:0]];
    end
  end

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 12'd0;
      row_q   <= 12'd0;
      col_q   <= 12'd0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      byte_q  <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign text_addr = addr_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
